// File: rtl/load_unit.sv
// Load unit: accepts one load request, reads the containing word from data
// memory, then returns the selected byte/half/word, sign- or zero-extended.
// Misaligned or illegal requests and memory timeouts complete with rsp_err=1.
module load_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    func3_q, func3_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic          req_bad;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;

    // Classify an incoming request as misaligned or carrying an illegal func3.
    always_comb begin
        req_bad = 1'b0;
        case (func3)
            F3_LB, F3_LBU: req_bad = 1'b0;
            F3_LH, F3_LHU: req_bad = addr[0];
            F3_LW:         req_bad = (addr[1:0] != 2'b00);
            default:       req_bad = 1'b1;
        endcase
    end

    // Select and extend the requested lane of the returned memory word.
    always_comb begin
        byte_sel  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (func3_q)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Next-state and response-register logic.
    always_comb begin
        state_d    = state_q;
        func3_d    = func3_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    func3_d = func3;
                    addr_d  = addr;
                    if (req_bad) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Data arriving on the last allowed cycle still completes normally.
                if (mem_rvalid) begin
                    rsp_data_d = load_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            func3_q    <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            func3_q    <= func3_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
